// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues sequential IMEM reads and buffers {word, pc} for decode.
// Define FETCH_BYPASS_EN to let an arriving word skip an empty queue in the same cycle.
module instr_fetch_queue #(
    parameter int unsigned         PC_WIDTH     = 32,
    parameter int unsigned         INSTR_WIDTH  = 32,
    parameter int unsigned         DEPTH        = 4,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = 32'h0040_0000
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [PC_WIDTH-1:0]    PC_IN,
    input  logic                   REDIRECT,
    output logic                   IMEM_REQ,
    output logic [PC_WIDTH-1:0]    IMEM_ADDR,
    input  logic [INSTR_WIDTH-1:0] IMEM_RDATA,
    output logic [INSTR_WIDTH-1:0] INSTR_OUT,
    output logic [PC_WIDTH-1:0]    INSTR_PC,
    output logic                   INSTR_VALID,
    input  logic                   INSTR_READY
);

    localparam int unsigned     PtrW     = $clog2(DEPTH);
    localparam int unsigned     CntW     = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    logic [PC_WIDTH-1:0]    fetch_ptr_q, fetch_ptr_d;
    logic [PC_WIDTH-1:0]    req_addr_q, req_addr_d;
    logic                   inflight_q, inflight_d;
    logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]        count_q, count_d;
    logic [INSTR_WIDTH-1:0] data_q [DEPTH];
    logic [PC_WIDTH-1:0]    pc_q   [DEPTH];

    logic            issue, resp, head_vld, bypass, push, pop;
    logic [CntW-1:0] occupancy;

    always_comb begin
        // Credit: entries held plus the one word that may still be in flight.
        occupancy = count_q + CntW'(inflight_q);
        issue     = RST & ~REDIRECT & (occupancy < DepthCnt);
        resp      = inflight_q & ~REDIRECT;
        head_vld  = (count_q != '0);
`ifdef FETCH_BYPASS_EN
        bypass    = resp & ~head_vld;
`else
        bypass    = 1'b0;
`endif
        pop       = head_vld & ~REDIRECT & INSTR_READY;
        push      = resp & ~(bypass & INSTR_READY);

        IMEM_REQ    = issue;
        IMEM_ADDR   = RST ? fetch_ptr_q : '0;
        INSTR_VALID = (head_vld | bypass) & ~REDIRECT;
        INSTR_OUT   = '0;
        INSTR_PC    = '0;
        if (head_vld) begin
            INSTR_OUT = data_q[rd_ptr_q];
            INSTR_PC  = pc_q[rd_ptr_q];
        end else if (bypass) begin
            INSTR_OUT = IMEM_RDATA;
            INSTR_PC  = req_addr_q;
        end
    end

    always_comb begin
        fetch_ptr_d = fetch_ptr_q;
        req_addr_d  = req_addr_q;
        inflight_d  = 1'b0;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        if (REDIRECT) begin
            // Low two bits are dropped to keep the fetch address word aligned.
            fetch_ptr_d = PC_IN & ~PC_WIDTH'(3);
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
        end else begin
            if (issue) begin
                fetch_ptr_d = fetch_ptr_q + PC_WIDTH'(4);
                req_addr_d  = fetch_ptr_q;
            end
            inflight_d = issue;
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            fetch_ptr_q <= RESET_VECTOR;
            req_addr_q  <= '0;
            inflight_q  <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            fetch_ptr_q <= fetch_ptr_d;
            req_addr_q  <= req_addr_d;
            inflight_q  <= inflight_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (push) begin
            data_q[wr_ptr_q] <= IMEM_RDATA;
            pc_q[wr_ptr_q]   <= req_addr_q;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_instr_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0040_0000;
`ifdef FETCH_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] PC_IN = '0;
    logic        REDIRECT = 1'b0;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic [31:0] IMEM_RDATA = '0;
    logic [31:0] INSTR_OUT;
    logic [31:0] INSTR_PC;
    logic        INSTR_VALID;
    logic        INSTR_READY = 1'b1;

    int checks = 0;
    int failures = 0;

    instr_fetch_queue dut (
        .CLK         (CLK),
        .RST         (RST),
        .PC_IN       (PC_IN),
        .REDIRECT    (REDIRECT),
        .IMEM_REQ    (IMEM_REQ),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_RDATA  (IMEM_RDATA),
        .INSTR_OUT   (INSTR_OUT),
        .INSTR_PC    (INSTR_PC),
        .INSTR_VALID (INSTR_VALID),
        .INSTR_READY (INSTR_READY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h2000_0000 + a;
    endfunction

    // Instruction memory: answers a request one cycle later; garbage when nothing was asked.
    logic [31:0] mem_addr = '0;
    bit          mem_hit = 1'b0;
    initial forever begin
        @(negedge CLK);
        mem_hit  = IMEM_REQ;
        mem_addr = IMEM_ADDR;
        @(posedge CLK);
        #1;
        IMEM_RDATA = mem_hit ? mem_word(mem_addr) : 32'hDEAD_BEEF;
    end

    // Reference model: a queue of delivered-to-be words plus one outstanding request.
    logic [31:0] q_pc[$];
    logic [31:0] q_ins[$];
    logic [31:0] m_fetch = RV;
    logic [31:0] m_addr = '0;
    bit          m_infl = 1'b0;
    bit          e_req, e_vld, byp_now, byp_used;
    logic [31:0] e_pc, e_out;

    initial forever begin
        @(negedge CLK);
        if (!RST) begin
            chk("rst_req", IMEM_REQ, 0);
            chk("rst_addr", IMEM_ADDR, 0);
            chk("rst_valid", INSTR_VALID, 0);
            chk("rst_out", INSTR_OUT, 0);
            chk("rst_pc", INSTR_PC, 0);
            q_pc.delete();
            q_ins.delete();
            m_fetch = RV;
            m_infl  = 1'b0;
        end else begin
            e_req   = (q_pc.size() + int'(m_infl)) < DEPTH && !REDIRECT;
            byp_now = Byp && q_pc.size() == 0 && m_infl && !REDIRECT;
            e_vld   = (q_pc.size() > 0 || byp_now) && !REDIRECT;
            e_pc    = '0;
            e_out   = '0;
            if (q_pc.size() > 0) begin
                e_pc  = q_pc[0];
                e_out = q_ins[0];
            end else if (byp_now) begin
                e_pc  = m_addr;
                e_out = mem_word(m_addr);
            end
            chk("imem_req", IMEM_REQ, e_req);
            if (e_req) chk("imem_addr", IMEM_ADDR, m_fetch);
            chk("instr_valid", INSTR_VALID, e_vld);
            chk("instr_pc", INSTR_PC, e_pc);
            chk("instr_out", INSTR_OUT, e_out);

            if (REDIRECT) begin
                q_pc.delete();
                q_ins.delete();
                m_fetch = PC_IN & 32'hFFFF_FFFC;
                m_infl  = 1'b0;
            end else begin
                byp_used = 1'b0;
                if (e_vld && INSTR_READY) begin
                    if (q_pc.size() > 0) begin
                        void'(q_pc.pop_front());
                        void'(q_ins.pop_front());
                    end else begin
                        byp_used = 1'b1;
                    end
                end
                if (m_infl && !byp_used) begin
                    q_pc.push_back(m_addr);
                    q_ins.push_back(mem_word(m_addr));
                end
                if (e_req) begin
                    m_addr  = m_fetch;
                    m_fetch = m_fetch + 32'd4;
                end
                m_infl = e_req;
            end
        end
    end

    task automatic drive(input logic r, input logic [31:0] pc, input logic rdy);
        @(posedge CLK);
        #1;
        REDIRECT    = r;
        PC_IN       = pc;
        INSTR_READY = rdy;
    endtask

    initial begin
        repeat (2) @(posedge CLK);

        // Streaming from reset with decode always ready.
        drive(0, 0, 1); RST = 1'b1;
        #1 chk("s1_req0", IMEM_REQ, 1); chk("s1_addr0", IMEM_ADDR, RV);
        drive(0, 0, 1);
        #1 chk("s1_addr1", IMEM_ADDR, 32'h0040_0004); chk("s1_vld1", INSTR_VALID, Byp);
        drive(0, 0, 1);
        #1 chk("s1_vld2", INSTR_VALID, 1);
        chk("s1_pc2", INSTR_PC, Byp ? 32'h0040_0004 : RV);
        chk("s1_out2", INSTR_OUT, Byp ? 32'h2040_0004 : 32'h2040_0000);
        repeat (5) drive(0, 0, 1);

        // Decode stalled from reset: queue fills, issue stops, then resumes without gap.
        drive(0, 0, 0); RST = 1'b0;
        drive(0, 0, 0); RST = 1'b1;
        repeat (4) drive(0, 0, 0);
        drive(0, 0, 0);
        #1 chk("s2_full_req", IMEM_REQ, 0); chk("s2_full_vld", INSTR_VALID, 1);
        chk("s2_full_pc", INSTR_PC, RV);
        drive(0, 0, 1);
        drive(0, 0, 1);
        #1 chk("s2_resume_req", IMEM_REQ, 1); chk("s2_resume_addr", IMEM_ADDR, 32'h0040_0010);
        chk("s2_resume_pc", INSTR_PC, 32'h0040_0004);
        repeat (8) drive(0, 0, 1);

        // Redirect with three queued and one in flight.
        drive(0, 0, 0); RST = 1'b0;
        drive(0, 0, 0); RST = 1'b1;
        repeat (3) drive(0, 0, 0);
        drive(1, 32'h0040_0100, 0);
        #1 chk("s3_redir_vld", INSTR_VALID, 0); chk("s3_redir_req", IMEM_REQ, 0);
        drive(0, 0, 0);
        #1 chk("s3_tgt_req", IMEM_REQ, 1); chk("s3_tgt_addr", IMEM_ADDR, 32'h0040_0100);
        drive(0, 0, 0);
        #1 chk("s3_vld_t2", INSTR_VALID, Byp);
        drive(0, 0, 0);
        #1 chk("s3_vld_t3", INSTR_VALID, 1); chk("s3_pc_t3", INSTR_PC, 32'h0040_0100);
        chk("s3_out_t3", INSTR_OUT, 32'h2040_0100);
        repeat (6) drive(0, 0, 1);

        // Address wrap and alignment of the redirect target.
        drive(1, 32'hFFFF_FFFC, 1);
        drive(0, 0, 1);
        #1 chk("s4_wrap_a", IMEM_ADDR, 32'hFFFF_FFFC);
        drive(0, 0, 1);
        #1 chk("s4_wrap_b", IMEM_ADDR, 32'h0000_0000);
        repeat (3) drive(0, 0, 1);
        drive(1, 32'h0040_0103, 1);
        drive(0, 0, 1);
        #1 chk("s4_align", IMEM_ADDR, 32'h0040_0100);
        repeat (3) drive(0, 0, 1);

        // Push and pop together at two entries, then stall to see it held two.
        drive(1, 32'h0000_1000, 0);
        repeat (3) drive(0, 0, 0);
        drive(0, 0, 1);
        drive(0, 0, 1);
        #1 chk("s5_order_pc", INSTR_PC, 32'h0000_1004); chk("s5_req", IMEM_REQ, 1);
        drive(0, 0, 0);
        drive(0, 0, 0);
        #1 chk("s5_full_req", IMEM_REQ, 0);
        repeat (3) drive(0, 0, 1);

        // Back-to-back redirects: only the last target streams.
        drive(1, 32'h0000_0100, 1);
        drive(1, 32'h0000_0200, 1);
        drive(0, 0, 1);
        #1 chk("s5_b2b_addr", IMEM_ADDR, 32'h0000_0200);
        drive(0, 0, 1);
        drive(0, 0, 1);
        #1 chk("s5_b2b_vld", INSTR_VALID, 1);
        chk("s5_b2b_pc", INSTR_PC, Byp ? 32'h0000_0204 : 32'h0000_0200);
        repeat (4) drive(0, 0, 1);

        // Asynchronous reset between edges, mid-stream.
        @(posedge CLK);
        #3 RST = 1'b0;
        #1 chk("s6_req", IMEM_REQ, 0); chk("s6_addr", IMEM_ADDR, 0);
        chk("s6_vld", INSTR_VALID, 0); chk("s6_out", INSTR_OUT, 0); chk("s6_pc", INSTR_PC, 0);
        drive(0, 0, 1);
        drive(0, 0, 1); RST = 1'b1;
        #1 chk("s6_restart_req", IMEM_REQ, 1); chk("s6_restart_addr", IMEM_ADDR, RV);
        repeat (6) drive(0, 0, 1);

        @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
